// File: rtl/uart_crypt_pkg.sv
// ----------------------------------------------------------------------------
// uart_crypt_pkg
// Definitions shared by the UART encrypt (TX) and decrypt (RX) controllers:
//   - default FIFO depth and ack timeout
//   - 2-bit controller FSM state encoding
//   - byte cipher enc(p, k)
// No ports (package).
// ----------------------------------------------------------------------------
package uart_crypt_pkg;

  localparam int UC_DEPTH       = 4;
  localparam int UC_ACK_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STROBE    = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } ctrl_state_t;

  // Key is spread over the three byte fields: top 2 bits take k[1:0],
  // middle and low 3-bit fields each take the full key.
  function automatic logic [7:0] enc(input logic [7:0] p, input logic [2:0] k);
    return {p[7:6] ^ k[1:0], p[5:3] ^ k, p[2:0] ^ k};
  endfunction

endpackage

// File: rtl/uart_crypt_fifo.sv
// ----------------------------------------------------------------------------
// uart_crypt_fifo
// DEPTH x WIDTH synchronous FIFO, first-word-fall-through head.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   push, din   write din on the rising edge when push=1 (never while full)
//   pop         advance head on the rising edge when pop=1 (never while empty)
//   dout        current head entry
//   count       entries stored, 0..DEPTH
//   full/empty  count==DEPTH / count==0
// Push and pop in the same clock leave count unchanged.
// ----------------------------------------------------------------------------
module uart_crypt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // NOTE: the storage array is deliberately not reset; count and the pointers
  // decide which entries are valid, so resetting data would only add logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/uart_crypt_tx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_crypt_tx_ctrl
// Takes plaintext bytes from the host, buffers them, encrypts each one with
// the key (baud_select) sampled at pop time, and hands them to the UART
// transmitter one frame at a time over the Tx_WR / Tx_BUSY handshake.
//
// Ports:
//   clk, reset       clock, async active-low reset
//   baud_select[2:0] encryption key (same value that picks the baud rate)
//   DATA_IN[7:0]     plaintext byte; taken on an edge with VALID & READY
//   DATA_IN_VALID    host offers DATA_IN
//   DATA_IN_READY    registered: 1 iff buffer has room
//   Tx_DATA[7:0]     encrypted byte, stable from strobe until frame ends
//   Tx_WR            one-clock write strobe to the transmitter
//   Tx_BUSY          transmitter busy with a frame
//   fifo_count       bytes buffered, 0..DEPTH
//   ctrl_busy        FSM not idle or bytes still buffered
//   tx_err           sticky: Tx_BUSY never answered a strobe within ACK_TIMEOUT
//
// Build option UART_CRYPT_KEY_ROLL_EN: the effective key becomes
// baud_select ^ seq, where seq counts strobed bytes (timed-out ones included)
// so the receiver can roll its key in step.
// ----------------------------------------------------------------------------
module uart_crypt_tx_ctrl
  import uart_crypt_pkg::*;
#(
  parameter int DEPTH       = UC_DEPTH,
  parameter int ACK_TIMEOUT = UC_ACK_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             baud_select,
  input  logic [7:0]             DATA_IN,
  input  logic                   DATA_IN_VALID,
  output logic                   DATA_IN_READY,
  output logic [7:0]             Tx_DATA,
  output logic                   Tx_WR,
  input  logic                   Tx_BUSY,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   ctrl_busy,
  output logic                   tx_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  ctrl_state_t   state_q, state_d;
  logic          push;
  logic          pop;
  logic          ack_timeout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] count_next;
  logic [TW-1:0] timer_q;
  logic [2:0]    key_now;

`ifdef UART_CRYPT_KEY_ROLL_EN
  logic [2:0] seq_q;

  // Every strobe advances seq, whether or not the byte is later acked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   seq_q <= '0;
    else if (state_q == ST_STROBE) seq_q <= seq_q + 3'd1;
  end

  assign key_now = baud_select ^ seq_q;
`else
  assign key_now = baud_select;
`endif

  assign push = DATA_IN_VALID & DATA_IN_READY & ~fifo_full;

  uart_crypt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .din   (DATA_IN),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-edge occupancy, so READY can be registered without a combinational
  // path from Tx_BUSY or pop to the host.
  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no latch can be inferred.
  always_comb begin
    count_next = fifo_count;
    if (push && !pop)      count_next = fifo_count + CW'(1);
    else if (pop && !push) count_next = fifo_count - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    ack_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Holding off while Tx_BUSY is high keeps Tx_WR out of a live frame.
        if (!fifo_empty && !Tx_BUSY) begin
          pop     = 1'b1;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE:   state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (Tx_BUSY) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          ack_timeout = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_WAIT_DONE: if (!Tx_BUSY) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      DATA_IN_READY <= 1'b0;
      Tx_DATA       <= '0;
      Tx_WR         <= 1'b0;
      timer_q       <= '0;
      tx_err        <= 1'b0;
    end else begin
      DATA_IN_READY <= (count_next < CW'(DEPTH));
      // Key is captured with the byte; later baud_select changes wait for
      // the next pop.
      if (pop) Tx_DATA <= enc(fifo_head, key_now);
      // Registered strobe: one clock, launched by the STROBE state.
      Tx_WR <= (state_q == ST_STROBE);
      if (state_q != ST_WAIT_ACK) timer_q <= '0;
      else                        timer_q <= timer_q + TW'(1);
      if (ack_timeout) tx_err <= 1'b1;
    end
  end

  assign ctrl_busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_crypt_tx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_crypt_tx_ctrl
// Directed bench for uart_crypt_tx_ctrl (DEPTH=4, ACK_TIMEOUT=16). A small
// transmitter model answers Tx_WR with Tx_BUSY and records every strobed byte.
// Outputs are sampled and inputs driven on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_uart_crypt_tx_ctrl;

  localparam int MODE_AUTO = 0;  // busy one clock after Tx_WR, for BUSY_LEN clocks
  localparam int MODE_HIGH = 1;  // busy stuck high
  localparam int MODE_LOW  = 2;  // busy stuck low
  localparam int BUSY_LEN  = 10;

  logic       clk;
  logic       rst_n;
  logic [2:0] baud_select;
  logic [7:0] DATA_IN;
  logic       DATA_IN_VALID;
  logic       DATA_IN_READY;
  logic [7:0] Tx_DATA;
  logic       Tx_WR;
  logic       Tx_BUSY;
  logic [2:0] fifo_count;
  logic       ctrl_busy;
  logic       tx_err;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         busy_mode = MODE_LOW;
  int         wr_count  = 0;
  logic [7:0] cap_q[$];

  uart_crypt_tx_ctrl dut (
    .clk           (clk),
    .reset         (rst_n),
    .baud_select   (baud_select),
    .DATA_IN       (DATA_IN),
    .DATA_IN_VALID (DATA_IN_VALID),
    .DATA_IN_READY (DATA_IN_READY),
    .Tx_DATA       (Tx_DATA),
    .Tx_WR         (Tx_WR),
    .Tx_BUSY       (Tx_BUSY),
    .fifo_count    (fifo_count),
    .ctrl_busy     (ctrl_busy),
    .tx_err        (tx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model and strobe recorder.
  initial begin : uart_model
    int  left;
    bit  pending;
    Tx_BUSY = 1'b0;
    left    = 0;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (Tx_WR === 1'b1) begin
        n_checks++;
        if (Tx_BUSY !== 1'b0) begin
          n_fail++;
          $display("FAIL wr_while_busy: Tx_BUSY=%b at strobe, required 0", Tx_BUSY);
        end
        cap_q.push_back(Tx_DATA);
        wr_count++;
      end
      case (busy_mode)
        MODE_HIGH: begin Tx_BUSY = 1'b1; left = 0; pending = 1'b0; end
        MODE_LOW:  begin Tx_BUSY = 1'b0; left = 0; pending = 1'b0; end
        default: begin
          if (pending) begin
            Tx_BUSY = 1'b1; left = BUSY_LEN - 1; pending = 1'b0;
          end else if (left > 0) begin
            left--;
          end else begin
            Tx_BUSY = 1'b0;
          end
          if (Tx_WR === 1'b1) pending = 1'b1;
        end
      endcase
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cap_q.delete();
  endtask

  // Offer one byte and return on the falling edge after it is taken.
  task automatic push_byte(input logic [7:0] b);
    bit ok = 1'b0;
    DATA_IN       = b;
    DATA_IN_VALID = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (DATA_IN_READY === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    DATA_IN_VALID = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL push_accept: byte %h not accepted within 100 clocks", b);
    end
  endtask

  // Return on the falling edge where Tx_WR is seen high.
  task automatic wait_wr(input int budget);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (Tx_WR === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_wr: no Tx_WR within %0d clocks", budget);
    end
  endtask

  task automatic wait_captures(input int n, input int budget);
    for (int i = 0; i < budget && cap_q.size() < n; i++) @(negedge clk);
    n_checks++;
    if (cap_q.size() < n) begin
      n_fail++;
      $display("FAIL captures: got %0d strobed bytes, required %0d", cap_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks += 6;
    if (Tx_DATA !== 8'h00)      begin n_fail++; $display("FAIL rst_tx_data: %h, required 00", Tx_DATA); end
    if (Tx_WR !== 1'b0)         begin n_fail++; $display("FAIL rst_tx_wr: %b, required 0", Tx_WR); end
    if (tx_err !== 1'b0)        begin n_fail++; $display("FAIL rst_tx_err: %b, required 0", tx_err); end
    if (DATA_IN_READY !== 1'b0) begin n_fail++; $display("FAIL rst_ready: %b, required 0", DATA_IN_READY); end
    if (fifo_count !== 3'd0)    begin n_fail++; $display("FAIL rst_count: %0d, required 0", fifo_count); end
    if (ctrl_busy !== 1'b0)     begin n_fail++; $display("FAIL rst_ctrl_busy: %b, required 0", ctrl_busy); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (DATA_IN_READY !== 1'b1) begin n_fail++; $display("FAIL rst_ready_rise: %b, required 1", DATA_IN_READY); end
  endtask

  task automatic test_single_byte();
    int base;
    do_reset();
    busy_mode   = MODE_AUTO;
    baud_select = 3'b101;
    @(negedge clk);
    @(negedge clk);
    cap_q.delete();
    base = wr_count;
    DATA_IN       = 8'hA5;
    DATA_IN_VALID = 1'b1;
    @(negedge clk);  // accepted at E0
    DATA_IN_VALID = 1'b0;
    n_checks += 3;
    if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count_e0: %0d, required 1", fifo_count); end
    if (Tx_WR !== 1'b0)      begin n_fail++; $display("FAIL single_wr_e0: %b, required 0", Tx_WR); end
    if (ctrl_busy !== 1'b1)  begin n_fail++; $display("FAIL single_ctrl_busy: %b, required 1", ctrl_busy); end
    @(negedge clk);  // after E1: popped
    n_checks += 3;
    if (Tx_DATA !== 8'hC8)   begin n_fail++; $display("FAIL single_data_e1: %h, required C8", Tx_DATA); end
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_count_e1: %0d, required 0", fifo_count); end
    if (Tx_WR !== 1'b0)      begin n_fail++; $display("FAIL single_wr_e1: %b, required 0", Tx_WR); end
    @(negedge clk);  // after E2: strobe
    n_checks++;
    if (Tx_WR !== 1'b1)      begin n_fail++; $display("FAIL single_wr_e2: %b, required 1", Tx_WR); end
    @(negedge clk);  // after E3
    n_checks++;
    if (Tx_WR !== 1'b0)      begin n_fail++; $display("FAIL single_wr_e3: %b, required 0", Tx_WR); end
    for (int i = 0; i < 50 && (ctrl_busy !== 1'b0 || Tx_BUSY !== 1'b0); i++) @(negedge clk);
    n_checks += 3;
    if (ctrl_busy !== 1'b0)     begin n_fail++; $display("FAIL single_idle: ctrl_busy %b, required 0", ctrl_busy); end
    if (wr_count - base !== 1)  begin n_fail++; $display("FAIL single_wr_count: %0d, required 1", wr_count - base); end
    if (Tx_DATA !== 8'hC8)      begin n_fail++; $display("FAIL single_data_hold: %h, required C8", Tx_DATA); end
  endtask

  task automatic test_fill();
    int         base;
    logic [7:0] exp_b [5];
    exp_b = '{8'h83, 8'hB0, 8'hA1, 8'hD6, 8'hC7};  // plaintext ^ 8'h92 for key 010
    do_reset();
    busy_mode   = MODE_HIGH;
    baud_select = 3'b010;
    @(negedge clk);
    @(negedge clk);
    cap_q.delete();
    base = wr_count;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    n_checks += 2;
    if (fifo_count !== 3'd4)    begin n_fail++; $display("FAIL fill_count: %0d, required 4", fifo_count); end
    if (DATA_IN_READY !== 1'b0) begin n_fail++; $display("FAIL fill_ready: %b, required 0", DATA_IN_READY); end
    DATA_IN       = 8'h55;
    DATA_IN_VALID = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 3;
    if (fifo_count !== 3'd4)    begin n_fail++; $display("FAIL fill_held_count: %0d, required 4", fifo_count); end
    if (DATA_IN_READY !== 1'b0) begin n_fail++; $display("FAIL fill_held_ready: %b, required 0", DATA_IN_READY); end
    if (wr_count !== base)      begin n_fail++; $display("FAIL fill_no_wr: %0d strobes, required 0", wr_count - base); end
    busy_mode = MODE_AUTO;
    push_byte(8'h55);
    wait_captures(5, 500);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= cap_q.size() || cap_q[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL fill_order[%0d]: %h, required %h", i,
                 (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp_b[i]);
      end
    end
  endtask

  task automatic test_key_change();
    do_reset();
    busy_mode   = MODE_AUTO;
    baud_select = 3'b000;
    @(negedge clk);
    @(negedge clk);
    cap_q.delete();
    push_byte(8'h3C);
    push_byte(8'h00);
    wait_wr(20);
    repeat (3) @(negedge clk);  // now in WAIT_DONE
    baud_select = 3'b111;
    repeat (2) @(negedge clk);
    n_checks++;
    if (Tx_DATA !== 8'h3C) begin n_fail++; $display("FAIL key_hold: %h, required 3C", Tx_DATA); end
    wait_captures(2, 200);
    n_checks += 2;
    if (cap_q.size() < 1 || cap_q[0] !== 8'h3C) begin n_fail++; $display("FAIL key_first: required 3C"); end
    if (cap_q.size() < 2 || cap_q[1] !== 8'hFF) begin n_fail++; $display("FAIL key_second: required FF"); end
  endtask

  task automatic test_timeout();
    do_reset();
    busy_mode   = MODE_LOW;
    baud_select = 3'b000;
    @(negedge clk);
    @(negedge clk);
    cap_q.delete();
    push_byte(8'h5A);
    push_byte(8'h6B);
    wait_wr(20);
    repeat (15) @(negedge clk);
    n_checks++;
    if (tx_err !== 1'b0) begin n_fail++; $display("FAIL timeout_early: tx_err %b, required 0", tx_err); end
    @(negedge clk);
    n_checks++;
    if (tx_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: tx_err %b, required 1", tx_err); end
    wait_captures(2, 40);
    n_checks++;
    if (cap_q.size() < 2 || cap_q[1] !== 8'h6B) begin n_fail++; $display("FAIL timeout_next: required 6B"); end
    repeat (25) @(negedge clk);
    n_checks += 2;
    if (tx_err !== 1'b1)    begin n_fail++; $display("FAIL timeout_sticky: %b, required 1", tx_err); end
    if (ctrl_busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: %b, required 0", ctrl_busy); end
  endtask

  task automatic test_reset_midframe();
    int base;
    busy_mode = MODE_LOW;
    @(negedge clk);
    @(negedge clk);
    push_byte(8'hA1);
    push_byte(8'hB2);
    push_byte(8'hC3);
    push_byte(8'hD4);
    n_checks++;
    if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL mid_count: %0d, required 3", fifo_count); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    base = wr_count;
    n_checks += 6;
    if (Tx_DATA !== 8'h00)      begin n_fail++; $display("FAIL mid_rst_data: %h, required 00", Tx_DATA); end
    if (Tx_WR !== 1'b0)         begin n_fail++; $display("FAIL mid_rst_wr: %b, required 0", Tx_WR); end
    if (tx_err !== 1'b0)        begin n_fail++; $display("FAIL mid_rst_err: %b, required 0", tx_err); end
    if (DATA_IN_READY !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: %b, required 0", DATA_IN_READY); end
    if (fifo_count !== 3'd0)    begin n_fail++; $display("FAIL mid_rst_count: %0d, required 0", fifo_count); end
    if (ctrl_busy !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_busy: %b, required 0", ctrl_busy); end
    @(negedge clk);
    rst_n     = 1'b1;
    busy_mode = MODE_AUTO;
    repeat (40) @(negedge clk);
    n_checks += 2;
    if (wr_count !== base)   begin n_fail++; $display("FAIL mid_no_wr: %0d strobes, required 0", wr_count - base); end
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_count_after: %0d, required 0", fifo_count); end
  endtask

`ifdef UART_CRYPT_KEY_ROLL_EN
  task automatic test_key_roll();
    do_reset();
    busy_mode   = MODE_AUTO;
    baud_select = 3'b000;
    @(negedge clk);
    @(negedge clk);
    cap_q.delete();
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'h00);
    wait_captures(3, 300);
    n_checks += 3;
    if (cap_q.size() < 1 || cap_q[0] !== 8'h00) begin n_fail++; $display("FAIL roll_0: required 00"); end
    if (cap_q.size() < 2 || cap_q[1] !== 8'h49) begin n_fail++; $display("FAIL roll_1: required 49"); end
    if (cap_q.size() < 3 || cap_q[2] !== 8'h92) begin n_fail++; $display("FAIL roll_2: required 92"); end
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    baud_select   = 3'b000;
    DATA_IN       = 8'h00;
    DATA_IN_VALID = 1'b0;
    test_reset();
`ifdef UART_CRYPT_KEY_ROLL_EN
    test_key_roll();
`else
    test_single_byte();
    test_fill();
    test_key_change();
    test_timeout();
    test_reset_midframe();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
